// File: rtl/sig_dump_ctrl_pkg.sv
// Shared encodings for sig_dump_ctrl: final status codes, FSM states and
// the end_signature / end-flag offsets from begin_signature.
package sig_dump_ctrl_pkg;

    typedef logic [1:0] status_t;

    localparam status_t ST_RUN       = 2'b00;
    localparam status_t ST_PASS      = 2'b01;
    localparam status_t ST_TIMEOUT   = 2'b10;
    localparam status_t ST_BAD_RANGE = 2'b11;

    typedef enum logic [2:0] {
        S_RUN     = 3'd0,
        S_ISSUE   = 3'd1,
        S_WAIT    = 3'd2,
        S_PRESENT = 3'd3,
        S_DONE    = 3'd4
    } state_t;

    localparam int unsigned END_OFS  = 4;
    localparam int unsigned FLAG_OFS = 8;

endpackage

// File: rtl/sig_dump_ctrl_if.sv
// Harness-side bus of sig_dump_ctrl: core write snoop, data-memory read port,
// signature stream and final status. master = controller, slave = harness.
interface sig_dump_ctrl_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32,
    parameter int RA_W   = 12
);
    logic                  wr_en;
    logic [ADDR_W-1:0]     wr_addr;
    logic [DATA_W-1:0]     wr_data;
    logic [DATA_W/8-1:0]   wr_be;

    logic                  rd_en;
    logic [RA_W-1:0]       rd_addr;
    logic [DATA_W-1:0]     rd_data;

    // sig_valid rises with sig_data/sig_last already stable and stays high,
    // unchanged, until a cycle where sig_ready is also high; that cycle moves the word.
    logic                  sig_valid;
    logic                  sig_ready;
    logic [DATA_W-1:0]     sig_data;
    logic                  sig_last;

    logic                  core_halt;
    logic                  done;
    logic [1:0]            status;
    logic [DATA_W-1:0]     sig_csum;

    modport master (
        input  wr_en, wr_addr, wr_data, wr_be, rd_data, sig_ready,
        output rd_en, rd_addr, sig_valid, sig_data, sig_last,
               core_halt, done, status, sig_csum
    );

    modport slave (
        output wr_en, wr_addr, wr_data, wr_be, rd_data, sig_ready,
        input  rd_en, rd_addr, sig_valid, sig_data, sig_last,
               core_halt, done, status, sig_csum
    );

endinterface

// File: rtl/sig_dump_ctrl_be_merge.sv
// sig_be_merge: byte-enable merge of a new word over an old word; a set
// enable bit takes that byte from new_i, a clear bit keeps old_i.
module sig_be_merge #(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0]   old_i,
    input  logic [DATA_W-1:0]   new_i,
    input  logic [DATA_W/8-1:0] be_i,
    output logic [DATA_W-1:0]   merged_o
);

    for (genvar b = 0; b < DATA_W / 8; b++) begin : g_byte
        assign merged_o[8*b +: 8] = be_i[b] ? new_i[8*b +: 8] : old_i[8*b +: 8];
    end

endmodule

// File: rtl/sig_dump_ctrl.sv
// sig_dump_ctrl: halts the core on end flag or timeout and streams the signature
// window out of data memory. Define SIG_CHECKSUM_EN to add the running checksum.
module sig_dump_ctrl
    import sig_dump_ctrl_pkg::*;
#(
    parameter int                DATA_W         = 32,
    parameter int                ADDR_W         = 32,
    parameter logic [ADDR_W-1:0] SIG_BASE_ADDR  = 'h1000_0008,
    parameter logic [ADDR_W-1:0] DMEM_BASE      = 'h1000,
    parameter int                DMEM_WORDS     = 3072,
    parameter int                TIMEOUT_CYCLES = 10240,
    parameter int                RD_LATENCY     = 1
) (
    input  logic            clk,
    input  logic            rst,
    sig_dump_ctrl_if.master bus,
    output state_t          dbg_state_o
);

    localparam int RA_W  = $clog2(DMEM_WORDS);
    localparam int TMR_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int LAT_W = $clog2(RD_LATENCY + 1);

    localparam logic [ADDR_W-1:0] END_ADDR  = SIG_BASE_ADDR + ADDR_W'(END_OFS);
    localparam logic [ADDR_W-1:0] FLAG_ADDR = SIG_BASE_ADDR + ADDR_W'(FLAG_OFS);
    localparam logic [ADDR_W:0]   DMEM_END  = {1'b0, DMEM_BASE} + (ADDR_W + 1)'(4 * DMEM_WORDS);

    state_t              state_q, state_d;
    logic [DATA_W-1:0]   begin_q, begin_d, end_q, end_d;
    logic [TMR_W-1:0]    timer_q, timer_d;
    logic [RA_W-1:0]     idx_q, idx_d, last_q, last_d;
    logic [LAT_W-1:0]    wait_q, wait_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic                halt_q, halt_d;
    status_t             pend_q, pend_d;

    logic [DATA_W-1:0]   begin_mrg, end_mrg, flag_mrg;
    logic [ADDR_W-1:0]   begin_a, end_a;
    logic                flag_hit, timeout_hit, trigger, range_ok, accept;

    sig_be_merge #(.DATA_W(DATA_W)) u_mrg_begin (
        .old_i(begin_q), .new_i(bus.wr_data), .be_i(bus.wr_be), .merged_o(begin_mrg));
    sig_be_merge #(.DATA_W(DATA_W)) u_mrg_end (
        .old_i(end_q), .new_i(bus.wr_data), .be_i(bus.wr_be), .merged_o(end_mrg));
    // The flag word is judged on this write alone, not on earlier flag writes.
    sig_be_merge #(.DATA_W(DATA_W)) u_mrg_flag (
        .old_i('0), .new_i(bus.wr_data), .be_i(bus.wr_be), .merged_o(flag_mrg));

    assign begin_a     = ADDR_W'(begin_q);
    assign end_a       = ADDR_W'(end_q);
    assign flag_hit    = bus.wr_en && (bus.wr_addr == FLAG_ADDR) && (flag_mrg == DATA_W'(1));
    assign timeout_hit = (timer_q == TMR_W'(TIMEOUT_CYCLES - 1));
    assign trigger     = (state_q == S_RUN) && (flag_hit || timeout_hit);
    assign accept      = (state_q == S_PRESENT) && bus.sig_ready;
    assign range_ok    = (begin_a[1:0] == 2'b00) && (end_a[1:0] == 2'b00) &&
                         (begin_a >= DMEM_BASE) && (begin_a <= end_a) &&
                         ({1'b0, end_a} <= DMEM_END);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_RUN;
            begin_q <= '0;
            end_q   <= '0;
            timer_q <= '0;
            idx_q   <= '0;
            last_q  <= '0;
            wait_q  <= '0;
            data_q  <= '0;
            halt_q  <= 1'b0;
            pend_q  <= ST_RUN;
        end else begin
            state_q <= state_d;
            begin_q <= begin_d;
            end_q   <= end_d;
            timer_q <= timer_d;
            idx_q   <= idx_d;
            last_q  <= last_d;
            wait_q  <= wait_d;
            data_q  <= data_d;
            halt_q  <= halt_d;
            pend_q  <= pend_d;
        end
    end

    always_comb begin
        state_d = state_q;
        begin_d = begin_q;
        end_d   = end_q;
        timer_d = timer_q;
        idx_d   = idx_q;
        last_d  = last_q;
        wait_d  = wait_q;
        data_d  = data_q;
        halt_d  = halt_q;
        pend_d  = pend_q;
        case (state_q)
            S_RUN: begin
                timer_d = timer_q + TMR_W'(1);
                if (bus.wr_en && bus.wr_addr == SIG_BASE_ADDR) begin_d = begin_mrg;
                if (bus.wr_en && bus.wr_addr == END_ADDR)      end_d   = end_mrg;
                if (trigger) begin
                    halt_d = 1'b1;
                    pend_d = flag_hit ? ST_PASS : ST_TIMEOUT;
                    if (!range_ok) begin
                        pend_d  = ST_BAD_RANGE;
                        state_d = S_DONE;
                    end else if (begin_a == end_a) begin
                        state_d = S_DONE;
                    end else begin
                        idx_d   = RA_W'((begin_a - DMEM_BASE) >> 2);
                        last_d  = RA_W'(((end_a - DMEM_BASE) >> 2) - ADDR_W'(1));
                        state_d = S_ISSUE;
                    end
                end
            end
            S_ISSUE: begin
                wait_d  = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (wait_q == LAT_W'(RD_LATENCY - 1)) begin
                    data_d  = bus.rd_data;
                    state_d = S_PRESENT;
                end else begin
                    wait_d = wait_q + LAT_W'(1);
                end
            end
            S_PRESENT: begin
                if (bus.sig_ready) begin
                    if (idx_q == last_q) begin
                        state_d = S_DONE;
                    end else begin
                        idx_d   = idx_q + RA_W'(1);
                        state_d = S_ISSUE;
                    end
                end
            end
            S_DONE:  state_d = S_DONE;
            default: state_d = S_RUN;
        endcase
    end

    always_comb begin
        bus.rd_en     = (state_q == S_ISSUE);
        bus.rd_addr   = (state_q == S_ISSUE) ? idx_q : '0;
        bus.sig_valid = (state_q == S_PRESENT);
        bus.sig_last  = (state_q == S_PRESENT) && (idx_q == last_q);
        bus.sig_data  = data_q;
        bus.core_halt = halt_q;
        bus.done      = (state_q == S_DONE);
        bus.status    = (state_q == S_DONE) ? pend_q : ST_RUN;
        dbg_state_o   = state_q;
    end

`ifdef SIG_CHECKSUM_EN
    logic [DATA_W-1:0] csum_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)         csum_q <= '0;
        else if (trigger) csum_q <= '0;
        else if (accept)  csum_q <= csum_q + data_q;
    end

    assign bus.sig_csum = csum_q;
`else
    assign bus.sig_csum = '0;
`endif

endmodule

// File: tb/tb_sig_dump_ctrl.sv
// Bench for sig_dump_ctrl: two instances (read latency 1 and 3) share one
// stimulus stream; each has its own memory pipe, expected queue and monitor.
module tb_sig_dump_ctrl;
    import sig_dump_ctrl_pkg::*;

    localparam int          DMEM_WORDS = 3072;
    localparam int          RA_W       = $clog2(DMEM_WORDS);
    localparam int          TIMEOUT    = 64;
    localparam int          BUDGET     = 2000;
    localparam logic [31:0] SIG_BASE   = 32'h1000_0008;
    localparam logic [31:0] DMEM_BASE  = 32'h1000;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        wr_en = 1'b0;
    logic [31:0] wr_addr = '0;
    logic [31:0] wr_data = '0;
    logic [3:0]  wr_be = '0;
    logic        sig_ready = 1'b0;
    int          ready_mode = 0;

    logic [31:0] mem [DMEM_WORDS];
    logic [31:0] exp_csum;
    int          n_checks = 0;
    int          n_errors = 0;

    logic [1:0]           rden_w, valid_w, last_w, halt_w, done_w;
    logic [1:0][1:0]      status_w;
    logic [1:0][RA_W-1:0] addr_w;
    logic [1:0][31:0]     data_w, csum_w;
    logic [1:0][2:0]      state_w;

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%h expected=%h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : g_inst
        localparam int LAT = (g == 0) ? 1 : 3;

        sig_dump_ctrl_if #(.DATA_W(32), .ADDR_W(32), .RA_W(RA_W)) bus ();
        state_t      dbg_state;
        logic [31:0] pipe [LAT];
        logic [31:0] exp_q [$];
        logic [31:0] held;
        logic [31:0] w;
        logic        stalled = 1'b0;
        logic        lat_pend = 1'b0;
        int          lat_cyc = 0;

        assign bus.wr_en     = wr_en;
        assign bus.wr_addr   = wr_addr;
        assign bus.wr_data   = wr_data;
        assign bus.wr_be     = wr_be;
        assign bus.sig_ready = sig_ready;
        assign bus.rd_data   = pipe[LAT-1];

        sig_dump_ctrl #(
            .DATA_W(32), .ADDR_W(32), .SIG_BASE_ADDR(SIG_BASE), .DMEM_BASE(DMEM_BASE),
            .DMEM_WORDS(DMEM_WORDS), .TIMEOUT_CYCLES(TIMEOUT), .RD_LATENCY(LAT)
        ) u_dut (
            .clk(clk), .rst(rst), .bus(bus), .dbg_state_o(dbg_state)
        );

        // Memory answers exactly LAT cycles after rd_en; other slots carry junk.
        always @(posedge clk) begin
            pipe[0] <= bus.rd_en ? mem[bus.rd_addr] : 32'hDEAD_BEEF;
            for (int k = 1; k < LAT; k++) pipe[k] <= pipe[k-1];
        end

        assign rden_w[g]   = bus.rd_en;
        assign valid_w[g]  = bus.sig_valid;
        assign last_w[g]   = bus.sig_last;
        assign halt_w[g]   = bus.core_halt;
        assign done_w[g]   = bus.done;
        assign status_w[g] = bus.status;
        assign addr_w[g]   = bus.rd_addr;
        assign data_w[g]   = bus.sig_data;
        assign csum_w[g]   = bus.sig_csum;
        assign state_w[g]  = dbg_state;

        always @(negedge clk) begin
            if (!rst) begin
                stalled  = 1'b0;
                lat_pend = 1'b0;
            end else begin
                if (stalled) begin
                    check("valid_held", bus.sig_valid, 1);
                    check("data_held", bus.sig_data, held);
                end
                if (lat_pend) begin
                    lat_cyc++;
                    if (bus.sig_valid) begin
                        check("rd_to_valid", lat_cyc, LAT + 1);
                        lat_pend = 1'b0;
                    end
                end
                if (bus.rd_en) begin
                    lat_pend = 1'b1;
                    lat_cyc  = 0;
                end
                stalled = bus.sig_valid && !sig_ready;
                held    = bus.sig_data;
                if (bus.sig_valid && sig_ready) begin
                    check("word_expected", exp_q.size() != 0, 1);
                    if (exp_q.size() != 0) begin
                        w = exp_q.pop_front();
                        check("sig_data", bus.sig_data, w);
                        check("sig_last", bus.sig_last, exp_q.size() == 0);
                    end
                end
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0:       sig_ready = 1'b1;
                1:       sig_ready = ($urandom_range(0, 2) == 0);
                default: sig_ready = 1'b0;
            endcase
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
        wr_en = 1'b1; wr_addr = a; wr_data = d; wr_be = be;
        step(1);
        wr_en = 1'b0; wr_addr = '0; wr_data = '0; wr_be = '0;
    endtask

    task automatic clear_expect();
        g_inst[0].exp_q.delete();
        g_inst[1].exp_q.delete();
        exp_csum = '0;
    endtask

    task automatic expect_range(input logic [31:0] b, input logic [31:0] e);
        logic [31:0] w;
        for (int a = int'(b); a < int'(e); a += 4) begin
            w = mem[(a - int'(DMEM_BASE)) >> 2];
            g_inst[0].exp_q.push_back(w);
            g_inst[1].exp_q.push_back(w);
            exp_csum += w;
        end
    endtask

    task automatic check_outputs_zero(input string tag);
        for (int g = 0; g < 2; g++) begin
            check({tag, "_ctl"}, {rden_w[g], valid_w[g], last_w[g], halt_w[g], done_w[g], status_w[g]}, 0);
            check({tag, "_rd_addr"}, addr_w[g], 0);
            check({tag, "_sig_data"}, data_w[g], 0);
            check({tag, "_csum"}, csum_w[g], 0);
            check({tag, "_state"}, state_w[g], S_RUN);
        end
    endtask

    // Leaves the bench in cycle 0 after reset release (timer at 0).
    task automatic do_reset(input string tag);
        rst = 1'b0;
        clear_expect();
        step(2);
        check_outputs_zero(tag);
        rst = 1'b1;
    endtask

    task automatic arm(input logic [31:0] b, input logic [31:0] e);
        bus_write(SIG_BASE, b, 4'hF);
        bus_write(SIG_BASE + 4, e, 4'hF);
    endtask

    task automatic wait_done(input string tag, input logic [1:0] exp_st);
        int cyc = 0;
        logic [31:0] csum_exp;
        while (done_w != 2'b11 && cyc < BUDGET) begin
            step(1);
            cyc++;
        end
        check({tag, "_done_in_time"}, cyc < BUDGET, 1);
        step(3);
`ifdef SIG_CHECKSUM_EN
        csum_exp = exp_csum;
`else
        csum_exp = '0;
`endif
        for (int g = 0; g < 2; g++) begin
            check({tag, "_done"}, done_w[g], 1);
            check({tag, "_status"}, status_w[g], exp_st);
            check({tag, "_halt"}, halt_w[g], 1);
            check({tag, "_valid_off"}, valid_w[g], 0);
            check({tag, "_csum"}, csum_w[g], csum_exp);
        end
        check({tag, "_left0"}, g_inst[0].exp_q.size(), 0);
        check({tag, "_left1"}, g_inst[1].exp_q.size(), 0);
    endtask

    initial begin
        int cyc;
        for (int i = 0; i < DMEM_WORDS; i++) mem[i] = 32'h5A5A_0000 ^ 32'(i);
        mem[1024] = 32'h11; mem[1025] = 32'h22; mem[1026] = 32'h33; mem[1027] = 32'h44;
        mem[3071] = 32'hC0DE_0001;
        for (int i = 0; i < 6; i++) mem[2048 + i] = $urandom;

        // Basic flag-triggered dump, sink always ready.
        do_reset("rst1");
        ready_mode = 0;
        expect_range(32'h2000, 32'h2010);
        arm(32'h2000, 32'h2010);
        bus_write(SIG_BASE + 8, 32'h1, 4'hF);
        wait_done("pass", ST_PASS);

        // Same window, sink ready one cycle in three.
        do_reset("rst2");
        ready_mode = 1;
        expect_range(32'h2000, 32'h2010);
        arm(32'h2000, 32'h2010);
        bus_write(SIG_BASE + 8, 32'h1, 4'hF);
        wait_done("stall", ST_PASS);

        // Pointers assembled from partial-byte writes, random data, random stalls.
        do_reset("rst3");
        expect_range(32'h3000, 32'h3018);
        bus_write(SIG_BASE, 32'hABCD_3000, 4'b0011);
        bus_write(SIG_BASE + 4, 32'h0000_0018, 4'b0001);
        bus_write(SIG_BASE + 4, 32'h0000_3000, 4'b0010);
        bus_write(SIG_BASE + 8, 32'h0000_0001, 4'b0001);
        wait_done("merge", ST_PASS);

        // Partial flag write is not a trigger; timeout fires at cycle 63.
        do_reset("rst4");
        ready_mode = 0;
        expect_range(32'h2000, 32'h2010);
        arm(32'h2000, 32'h2010);
        bus_write(SIG_BASE + 8, 32'h100, 4'b0010);
        step(60);
        check("halt_before_timeout0", halt_w[0], 0);
        check("halt_before_timeout1", halt_w[1], 0);
        step(1);
        check("halt_after_timeout0", halt_w[0], 1);
        check("halt_after_timeout1", halt_w[1], 1);
        wait_done("timeout", ST_TIMEOUT);

        // Flag write lands in the timeout cycle: flag wins.
        do_reset("rst5");
        expect_range(32'h2000, 32'h2010);
        arm(32'h2000, 32'h2010);
        step(61);
        bus_write(SIG_BASE + 8, 32'h1, 4'hF);
        wait_done("tie", ST_PASS);

        // Bad and degenerate ranges.
        do_reset("rst6");
        arm(32'h2010, 32'h2000);
        bus_write(SIG_BASE + 8, 32'h1, 4'hF);
        wait_done("inverted", ST_BAD_RANGE);

        do_reset("rst7");
        arm(32'h2002, 32'h2010);
        bus_write(SIG_BASE + 8, 32'h1, 4'hF);
        wait_done("misaligned", ST_BAD_RANGE);

        do_reset("rst8");
        arm(32'h2000, 32'h4004);
        bus_write(SIG_BASE + 8, 32'h1, 4'hF);
        wait_done("past_end", ST_BAD_RANGE);

        do_reset("rst9");
        arm(32'h2000, 32'h2000);
        bus_write(SIG_BASE + 8, 32'h1, 4'hF);
        wait_done("empty", ST_PASS);

        do_reset("rst10");
        expect_range(32'h3FFC, 32'h4000);
        arm(32'h3FFC, 32'h4000);
        bus_write(SIG_BASE + 8, 32'h1, 4'hF);
        wait_done("top_word", ST_PASS);

        // Reset while a word is presented, then a clean dump.
        do_reset("rst11");
        ready_mode = 2;
        expect_range(32'h2000, 32'h2010);
        arm(32'h2000, 32'h2010);
        bus_write(SIG_BASE + 8, 32'h1, 4'hF);
        cyc = 0;
        while (!valid_w[0] && cyc < 100) begin
            step(1);
            cyc++;
        end
        check("present_reached", valid_w[0], 1);
        #2;
        rst = 1'b0;
        #1;
        check_outputs_zero("async_rst");
        step(1);
        do_reset("rst12");
        ready_mode = 0;
        expect_range(32'h2000, 32'h2010);
        arm(32'h2000, 32'h2010);
        bus_write(SIG_BASE + 8, 32'h1, 4'hF);
        wait_done("after_abort", ST_PASS);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #900_000;
        $display("FAIL watchdog: bench did not complete, errors=%0d checks=%0d", n_errors, n_checks);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/sig_dump_ctrl.md
Name: sig_dump_ctrl

Overview:
Synthesizable successor to the simulation-only signature dump: a test-harness controller beside CoreTop. It snoops core data-bus writes to the begin_signature, end_signature and end-flag words, and runs a cycle timeout. On the end flag or on timeout it halts the core, reads the signature window out of data memory through a read port, and streams the words out on a valid/ready interface. It then reports a final status.

Parameters:
DATA_W, 32, snoop and memory data width (multiple of 8)
ADDR_W, 32, byte-address width
SIG_BASE_ADDR, 'h1000_0008, address of begin_signature; end_signature is at +4, end flag at +8
DMEM_BASE, 'h1000, byte address of data-memory word 0
DMEM_WORDS, 3072, data-memory depth in words
TIMEOUT_CYCLES, 10240, cycles after reset before a forced dump
RD_LATENCY, 1, cycles from rd_en to valid rd_data (>=1)

Ports:
clk  in  1  system clock
rst  in  1  reset; asynchronous and active-low
wr_en  in  1  core data-bus write strobe
wr_addr  in  ADDR_W  write byte address
wr_data  in  DATA_W  write data
wr_be  in  DATA_W/8  byte enables
rd_en  out  1  data-memory read strobe
rd_addr  out  $clog2(DMEM_WORDS)  word index
rd_data  in  DATA_W  read data, valid RD_LATENCY cycles after rd_en
sig_valid  out  1  signature word valid
sig_ready  in  1  sink accepts word
sig_data  out  DATA_W  signature word
sig_last  out  1  final word of the window
core_halt  out  1  stall request to core
done  out  1  dump complete (sticky)
status  out  2  00 running, 01 PASS, 10 TIMEOUT, 11 BAD_RANGE
sig_csum  out  DATA_W  running checksum (see Optional Feature)

Behaviour:
- Reset (rst=0, async): FSM=RUN. begin_q, end_q, timer and all outputs are 0.
- Snoop in RUN only:
  - A write to SIG_BASE_ADDR or SIG_BASE_ADDR+4 merges wr_data into begin_q or end_q per byte, using wr_be.
  - A write to SIG_BASE_ADDR+8 whose byte-merged value (with prior content 0) equals 1 is the trigger.
  - Writes in any other state are ignored.
- Timer: increments each RUN cycle. Reaching TIMEOUT_CYCLES-1 with no trigger is a timeout trigger. If the flag trigger and timeout occur in the same cycle, the flag wins (PASS).
- On trigger:
  - core_halt goes high on the next edge and stays high until reset.
  - The pending status is latched: PASS or TIMEOUT.
  - Range check: begin_q[1:0]==0, end_q[1:0]==0, DMEM_BASE<=begin_q<=end_q<=DMEM_BASE+4*DMEM_WORDS.
  - If the check fails, go to DONE with status 11 and stream no words.
  - If begin_q==end_q, go to DONE with the latched status and stream no words.
  - Otherwise idx=(begin_q-DMEM_BASE)>>2 and last_idx=((end_q-DMEM_BASE)>>2)-1; go to ISSUE.
- States RUN -> ISSUE -> WAIT -> PRESENT -> (ISSUE | DONE).
- ISSUE: rd_en=1 and rd_addr=idx for exactly one cycle.
- WAIT: counts RD_LATENCY cycles, then captures rd_data into the sig_data register.
- PRESENT:
  - sig_valid=1; sig_data is held stable until sig_valid&&sig_ready.
  - sig_last=(idx==last_idx).
  - On acceptance: if last, go to DONE; else idx+1 and go to ISSUE.
  - sig_valid must not drop without acceptance.
- DONE: done=1, status = final code, sig_valid=0. Held until reset.
- Only one read is outstanding; throughput is one word per RD_LATENCY+2 cycles with sig_ready held high.
- Reset mid-dump aborts immediately; no partial done.

Optional Feature:
SIG_CHECKSUM_EN
- Defined: sig_csum clears on trigger and adds each accepted word, modulo 2^DATA_W. Its final value is stable once done=1.
- Undefined: sig_csum is tied to 0 and the adder is absent.

Decomposition:
- Shared package holds the status encodings (ST_RUN, ST_PASS, ST_TIMEOUT, ST_BAD_RANGE), the FSM state encodings, and the offsets 4/8 for end_signature and the end flag.
- One sub-module, sig_be_merge: combinational byte-enable merge of DATA_W words, reused for the begin, end and flag capture.

Test Plan:
1. Write begin='h2000, end='h2010, flag=1 with memory words at 'h2000.. = 11,22,33,44 and sig_ready=1 -> four words 11,22,33,44; sig_last on 44; done=1; status=01; csum='hAA when enabled.
2. Same as 1 but toggle sig_ready 1-in-3 -> the same four words in order, sig_data stable while stalled, no loss or duplicates.
3. No flag write, TIMEOUT_CYCLES=64, begin/end as in 1 -> dump starts after cycle 63; status=10; four words streamed.
4. begin='h2010, end='h2000 (inverted), or begin='h2002 -> no sig_valid; done=1; status=11.
5. Flag write and timeout in the same cycle -> status=01; a partial-byte flag write (wr_be=4'b0010, data 'h100) -> not a trigger.
6. Assert rst low during PRESENT -> all outputs 0 asynchronously; after release, a fresh dump works as in 1; RD_LATENCY=3 gives rd_en-to-sig_valid of 4 cycles.
